// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_IMISS = 2'd1,
      ST_DMISS = 2'd2,
      ST_ERR   = 2'd3
   } pipe_state_e;

   // Winning hazard cause for the current cycle, already priority-resolved
   typedef enum logic [2:0] {
      CS_RUN,
      CS_IMISS,
      CS_STALL,
      CS_BRANCH,
      CS_DMISS,
      CS_ERR
   } cause_e;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand; the nearer EX_MEM producer beats MEM_WB.
module fwd_unit
   import mips_pipe_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter bit FWD_EN = 1'b1
) (
   input  logic [REG_AW-1:0] src,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_dest,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_dest,
   output logic [1:0]        sel
);

   logic exmem_hit;
   logic memwb_hit;

   // $0 is hardwired, so a write to it never produces a forwardable value
   assign exmem_hit = exmem_reg_write && (exmem_dest != '0) && (exmem_dest == src);
   assign memwb_hit = memwb_reg_write && (memwb_dest != '0) && (memwb_dest == src);

   always_comb begin
      sel = FWD_RF;
      if (FWD_EN) begin
         if (exmem_hit) begin
            sel = FWD_EXMEM;
         end else if (memwb_hit) begin
            sel = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline: per-stage enables,
// bubble inserts, miss watchdog and saturating performance counters.
module pipe_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter bit FWD_EN       = 1'b1,
   parameter int MISS_TIMEOUT = 64,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ins_hit,
   input  logic              data_hit,
   input  logic              pc_src,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              idex_mem_read,
   input  logic              idex_reg_write,
   input  logic [REG_AW-1:0] idex_dest,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_dest,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_dest,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              memwb_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [1:0]        state,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // state | meaning
   // RUN   | normal flow, branch flush or RAW/load-use bubble
   // IMISS | waiting on I-cache, bubbles fed into IF_ID
   // DMISS | waiting on D-cache, whole pipeline frozen
   // ERR   | miss watchdog expired, pipeline frozen until rst

   localparam int MC_W = $clog2(MISS_TIMEOUT);
   localparam logic [MC_W-1:0] MISS_LAST = MC_W'(MISS_TIMEOUT - 1);

   pipe_state_e     state_q;
   pipe_state_e     state_d;
   cause_e          cause;
   logic [MC_W-1:0] miss_ctr;
   logic            miss_now;
   logic            miss_expired;

   logic            ld_use;
   logic            raw_idex;
   logic            raw_exmem;
   logic            raw_memwb;
   logic            stall_req;
   logic [1:0]      fwd_a_raw;
   logic [1:0]      fwd_b_raw;

   fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
      .src             (ex_rs),
      .exmem_reg_write (exmem_reg_write),
      .exmem_dest      (exmem_dest),
      .memwb_reg_write (memwb_reg_write),
      .memwb_dest      (memwb_dest),
      .sel             (fwd_a_raw)
   );

   fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
      .src             (ex_rt),
      .exmem_reg_write (exmem_reg_write),
      .exmem_dest      (exmem_dest),
      .memwb_reg_write (memwb_reg_write),
      .memwb_dest      (memwb_dest),
      .sel             (fwd_b_raw)
   );

   assign ld_use = idex_mem_read && (idex_dest != '0) &&
                   ((idex_dest == id_rs) || (id_uses_rt && (idex_dest == id_rt)));

   assign raw_idex  = idex_reg_write && (idex_dest != '0) &&
                      ((idex_dest == id_rs) || (id_uses_rt && (idex_dest == id_rt)));
   assign raw_exmem = exmem_reg_write && (exmem_dest != '0) &&
                      ((exmem_dest == id_rs) || (id_uses_rt && (exmem_dest == id_rt)));
   assign raw_memwb = memwb_reg_write && (memwb_dest != '0) &&
                      ((memwb_dest == id_rs) || (id_uses_rt && (memwb_dest == id_rt)));

   // Without forwarding every in-flight producer must drain to the register file
   assign stall_req = FWD_EN ? ld_use : (raw_idex || raw_exmem || raw_memwb);

   always_comb begin
      cause = CS_RUN;
      if (state_q == ST_ERR) begin
         cause = CS_ERR;
      end else if (!data_hit) begin
         cause = CS_DMISS;
      end else if (pc_src) begin
         cause = CS_BRANCH;
      end else if (stall_req) begin
         cause = CS_STALL;
      end else if (!ins_hit) begin
         cause = CS_IMISS;
      end
   end

   assign miss_now     = (cause == CS_DMISS) || (cause == CS_IMISS);
   assign miss_expired = (miss_ctr == MISS_LAST);

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      fwd_a       = fwd_a_raw;
      fwd_b       = fwd_b_raw;
      state_d     = ST_RUN;

      unique case (cause)
         CS_ERR: begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            fwd_a    = FWD_RF;
            fwd_b    = FWD_RF;
            state_d  = ST_ERR;
         end
         CS_DMISS: begin
            // EX_MEM stays frozen, so a pending pc_src is still valid afterwards
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = miss_expired ? ST_ERR : ST_DMISS;
         end
         CS_BRANCH: begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end
         CS_STALL: begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
         CS_IMISS: begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            state_d    = miss_expired ? ST_ERR : ST_IMISS;
         end
         default: begin
         end
      endcase

      if (rst) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         fwd_a       = FWD_RF;
         fwd_b       = FWD_RF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         miss_ctr    <= '0;
         timeout_err <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state_q <= state_d;

         if (miss_now && (state_d != ST_ERR)) begin
            miss_ctr <= miss_ctr + 1'b1;
         end else begin
            miss_ctr <= '0;
         end

         if (state_d == ST_ERR) begin
            timeout_err <= 1'b1;
         end

         if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end

         if ((cause == CS_BRANCH) && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three builds (default, no forwarding,
// short timeout with 8-bit counters) share one input bus.
module tb_pipe_hazard_ctrl;

   localparam int AW = 5;

   localparam logic [4:0] E_ALL   = 5'b11111;
   localparam logic [4:0] E_NONE  = 5'b00000;
   localparam logic [4:0] E_STALL = 5'b00111;
   localparam logic [4:0] E_IMISS = 5'b01111;
   localparam logic [2:0] F_NONE  = 3'b000;
   localparam logic [2:0] F_IFID  = 3'b100;
   localparam logic [2:0] F_IDEX  = 3'b010;
   localparam logic [2:0] F_BR    = 3'b111;
   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_IMISS = 2'd1;
   localparam logic [1:0] S_DMISS = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   typedef struct {
      logic          ins_hit, data_hit, pc_src, id_uses_rt;
      logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt;
      logic          idex_mem_read, idex_reg_write, exmem_reg_write, memwb_reg_write;
      logic [AW-1:0] idex_dest, exmem_dest, memwb_dest;
   } in_t;

   typedef struct {
      int          w;
      logic [13:0] v;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic ins_hit = 1'b1, data_hit = 1'b1, pc_src = 1'b0, id_uses_rt = 1'b0;
   logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0;
   logic idex_mem_read = 1'b0, idex_reg_write = 1'b0, exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
   logic [AW-1:0] idex_dest = '0, exmem_dest = '0, memwb_dest = '0;

   logic [2:0] pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic [2:0] ifid_flush, idex_flush, exmem_flush, timeout_err;
   logic [1:0] fwd_a [3];
   logic [1:0] fwd_b [3];
   logic [1:0] st [3];
   logic [31:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
   logic [7:0]  stall_cnt2, flush_cnt2;

   int total = 0;
   int bad   = 0;
   exp_t exp_q[$];

   pipe_hazard_ctrl #(.REG_AW(AW), .FWD_EN(1'b1), .MISS_TIMEOUT(64), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .ins_hit(ins_hit), .data_hit(data_hit), .pc_src(pc_src),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_dest(idex_dest),
      .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
      .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest),
      .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .idex_en(idex_en[0]), .exmem_en(exmem_en[0]),
      .memwb_en(memwb_en[0]), .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]),
      .exmem_flush(exmem_flush[0]), .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .state(st[0]),
      .timeout_err(timeout_err[0]), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
   );

   pipe_hazard_ctrl #(.REG_AW(AW), .FWD_EN(1'b0), .MISS_TIMEOUT(64), .CNT_W(32)) dut_nf (
      .clk(clk), .rst(rst), .ins_hit(ins_hit), .data_hit(data_hit), .pc_src(pc_src),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_dest(idex_dest),
      .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
      .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest),
      .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .idex_en(idex_en[1]), .exmem_en(exmem_en[1]),
      .memwb_en(memwb_en[1]), .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]),
      .exmem_flush(exmem_flush[1]), .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .state(st[1]),
      .timeout_err(timeout_err[1]), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
   );

   pipe_hazard_ctrl #(.REG_AW(AW), .FWD_EN(1'b1), .MISS_TIMEOUT(4), .CNT_W(8)) dut_to (
      .clk(clk), .rst(rst), .ins_hit(ins_hit), .data_hit(data_hit), .pc_src(pc_src),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_dest(idex_dest),
      .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
      .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest),
      .pc_en(pc_en[2]), .ifid_en(ifid_en[2]), .idex_en(idex_en[2]), .exmem_en(exmem_en[2]),
      .memwb_en(memwb_en[2]), .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]),
      .exmem_flush(exmem_flush[2]), .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .state(st[2]),
      .timeout_err(timeout_err[2]), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
   );

   function automatic logic [13:0] ctl(input logic [4:0] en, input logic [2:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [1:0] s);
      return {en, fl, fa, fb, s};
   endfunction

   function automatic logic [13:0] obs(input int w);
      return {pc_en[w], ifid_en[w], idex_en[w], exmem_en[w], memwb_en[w],
              ifid_flush[w], idex_flush[w], exmem_flush[w], fwd_a[w], fwd_b[w], st[w]};
   endfunction

   function automatic exp_t mk(input int w, input logic [13:0] v, input string n);
      exp_t e;
      e.w = w; e.v = v; e.name = n;
      return e;
   endfunction

   function automatic in_t idle_in();
      in_t s;
      s.ins_hit = 1'b1; s.data_hit = 1'b1; s.pc_src = 1'b0; s.id_uses_rt = 1'b0;
      s.id_rs = '0; s.id_rt = '0; s.ex_rs = '0; s.ex_rt = '0;
      s.idex_mem_read = 1'b0; s.idex_reg_write = 1'b0;
      s.exmem_reg_write = 1'b0; s.memwb_reg_write = 1'b0;
      s.idex_dest = '0; s.exmem_dest = '0; s.memwb_dest = '0;
      return s;
   endfunction

   task automatic apply(input in_t s);
      ins_hit = s.ins_hit; data_hit = s.data_hit; pc_src = s.pc_src; id_uses_rt = s.id_uses_rt;
      id_rs = s.id_rs; id_rt = s.id_rt; ex_rs = s.ex_rs; ex_rt = s.ex_rt;
      idex_mem_read = s.idex_mem_read; idex_reg_write = s.idex_reg_write; idex_dest = s.idex_dest;
      exmem_reg_write = s.exmem_reg_write; exmem_dest = s.exmem_dest;
      memwb_reg_write = s.memwb_reg_write; memwb_dest = s.memwb_dest;
   endtask

   task automatic drive(input in_t s);
      @(posedge clk); #1;
      apply(s);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      apply(idle_in());
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      apply(idle_in());
      @(posedge clk); #1;
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         logic [13:0] got;
         got = obs(w);
         total++;
         if (got[13:2] !== 12'b00000_111_0000) begin
            bad++;
            $display("FAIL reset_outputs dut%0d: got %b want 000001110000", w, got[13:2]);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({st[0], st[1], st[2]} !== 6'b0) begin
         bad++;
         $display("FAIL reset_state: got %b want 000000", {st[0], st[1], st[2]});
      end
      total++;
      if ({stall_cnt0, flush_cnt0, timeout_err} !== '0) begin
         bad++;
         $display("FAIL reset_counters: stall=%0d flush=%0d terr=%b want 0 0 000",
                  stall_cnt0, flush_cnt0, timeout_err);
      end
   endtask

   task automatic test_load_use();
      in_t s; exp_t e; logic [13:0] got;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         s = idle_in();
         case (i)
            0: begin
               s.id_rs = 2; s.id_rt = 4; s.id_uses_rt = 1; s.ex_rs = 1;
               s.idex_mem_read = 1; s.idex_reg_write = 1; s.idex_dest = 2;
            end
            1: begin
               s.id_rs = 2; s.id_rt = 4; s.id_uses_rt = 1;
               s.exmem_reg_write = 1; s.exmem_dest = 2;
            end
            2: begin
               s.id_rs = 7; s.id_rt = 8; s.ex_rs = 2; s.ex_rt = 4;
               s.memwb_reg_write = 1; s.memwb_dest = 2;
            end
            3, 4: begin
               s.id_rs = 3; s.id_rt = 4; s.id_uses_rt = (i == 4);
               s.idex_mem_read = 1; s.idex_reg_write = 1; s.idex_dest = 4;
            end
            default: begin
               s.id_uses_rt = 1; s.idex_mem_read = 1; s.idex_reg_write = 1;
            end
         endcase
         drive(s);
         if (i == 0 || i == 4)
            exp_q.push_back(mk(0, ctl(E_STALL, F_IDEX, 2'b00, 2'b00, S_RUN), "load_use_stall"));
         else
            exp_q.push_back(mk(0, ctl(E_ALL, F_NONE, (i == 2) ? 2'b01 : 2'b00, 2'b00, S_RUN),
                               "load_use_run"));
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.w);
            total++;
            if (got !== e.v) begin
               bad++;
               $display("FAIL %s dut%0d step%0d: got %b want %b", e.name, e.w, i, got, e.v);
            end
         end
         if (i == 2 || i == 5) begin
            total++;
            if (stall_cnt0 !== ((i == 2) ? 32'd1 : 32'd2)) begin
               bad++;
               $display("FAIL load_use_stall_cnt step%0d: got %0d want %0d", i, stall_cnt0,
                        (i == 2) ? 1 : 2);
            end
         end
      end
   endtask

   task automatic test_forwarding();
      in_t s; exp_t e; logic [13:0] got;
      logic [1:0] fa, fb;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         s = idle_in();
         case (i)
            0: begin
               s.exmem_reg_write = 1; s.exmem_dest = 5; s.memwb_reg_write = 1; s.memwb_dest = 6;
               s.ex_rs = 5; s.ex_rt = 6; fa = 2'b10; fb = 2'b01;
            end
            1: begin
               s.exmem_reg_write = 1; s.exmem_dest = 5; s.memwb_reg_write = 1; s.memwb_dest = 5;
               s.ex_rs = 5; s.ex_rt = 5; fa = 2'b10; fb = 2'b10;
            end
            2: begin
               s.exmem_reg_write = 1; s.memwb_reg_write = 1; s.idex_reg_write = 1;
               s.idex_mem_read = 1; s.id_uses_rt = 1; fa = 2'b00; fb = 2'b00;
            end
            3: begin
               s.exmem_dest = 5; s.memwb_reg_write = 1; s.memwb_dest = 5;
               s.ex_rs = 5; s.ex_rt = 3; fa = 2'b01; fb = 2'b00;
            end
            default: begin
               s.exmem_reg_write = 1; s.memwb_reg_write = 1; s.memwb_dest = 7;
               s.ex_rt = 7; fa = 2'b00; fb = 2'b01;
            end
         endcase
         drive(s);
         exp_q.push_back(mk(0, ctl(E_ALL, F_NONE, fa, fb, S_RUN), "fwd_sel"));
         exp_q.push_back(mk(1, ctl(E_ALL, F_NONE, 2'b00, 2'b00, S_RUN), "fwd_disabled"));
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.w);
            total++;
            if (got !== e.v) begin
               bad++;
               $display("FAIL %s dut%0d step%0d: got %b want %b", e.name, e.w, i, got, e.v);
            end
         end
      end
   endtask

   task automatic test_no_fwd();
      in_t s; exp_t e; logic [13:0] got;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         s = idle_in();
         s.id_rs = 5; s.id_rt = 7; s.id_uses_rt = 1;
         case (i)
            0: begin s.idex_reg_write = 1; s.idex_dest = 5; end
            1: begin s.exmem_reg_write = 1; s.exmem_dest = 5; end
            2: begin s.memwb_reg_write = 1; s.memwb_dest = 5; end
            3: begin
               s.id_rs = 0; s.id_rt = 0; s.exmem_reg_write = 1; s.exmem_dest = 9; s.ex_rs = 9;
            end
            default: begin
               s.id_rs = 1; s.id_rt = 5; s.id_uses_rt = (i == 5);
               s.memwb_reg_write = 1; s.memwb_dest = 5;
            end
         endcase
         drive(s);
         if (i < 3 || i == 5)
            exp_q.push_back(mk(1, ctl(E_STALL, F_IDEX, 2'b00, 2'b00, S_RUN), "nofwd_stall"));
         else
            exp_q.push_back(mk(1, ctl(E_ALL, F_NONE, 2'b00, 2'b00, S_RUN), "nofwd_run"));
         if (i == 3)
            exp_q.push_back(mk(0, ctl(E_ALL, F_NONE, 2'b10, 2'b00, S_RUN), "fwd_exmem"));
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.w);
            total++;
            if (got !== e.v) begin
               bad++;
               $display("FAIL %s dut%0d step%0d: got %b want %b", e.name, e.w, i, got, e.v);
            end
         end
         if (i == 3) begin
            total++;
            if (stall_cnt1 !== 32'd3) begin
               bad++;
               $display("FAIL nofwd_stall_cnt: got %0d want 3", stall_cnt1);
            end
         end
      end
   endtask

   task automatic test_dmiss_branch();
      in_t s; exp_t e; logic [13:0] got;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         s = idle_in();
         if (i < 5) begin
            s.data_hit = 0; s.pc_src = 1;
            exp_q.push_back(mk(0, ctl(E_NONE, F_NONE, 2'b00, 2'b00, (i == 0) ? S_RUN : S_DMISS),
                               "dmiss_freeze"));
         end else if (i == 5) begin
            s.pc_src = 1;
            exp_q.push_back(mk(0, ctl(E_ALL, F_BR, 2'b00, 2'b00, S_DMISS), "branch_after_dmiss"));
         end else if (i == 7 || i == 8) begin
            s.ins_hit = 0; s.pc_src = (i == 7);
            s.id_rs = 2; s.idex_mem_read = 1; s.idex_reg_write = 1; s.idex_dest = 2;
            if (i == 7)
               exp_q.push_back(mk(0, ctl(E_ALL, F_BR, 2'b00, 2'b00, S_RUN), "branch_wins"));
            else
               exp_q.push_back(mk(0, ctl(E_STALL, F_IDEX, 2'b00, 2'b00, S_RUN), "stall_over_imiss"));
         end else begin
            exp_q.push_back(mk(0, ctl(E_ALL, F_NONE, 2'b00, 2'b00, S_RUN), "post_branch_run"));
         end
         drive(s);
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.w);
            total++;
            if (got !== e.v) begin
               bad++;
               $display("FAIL %s dut%0d step%0d: got %b want %b", e.name, e.w, i, got, e.v);
            end
         end
         if (i == 6 || i == 9) begin
            total++;
            if (flush_cnt0 !== ((i == 6) ? 32'd1 : 32'd2) || stall_cnt0 !== ((i == 6) ? 32'd5 : 32'd6)) begin
               bad++;
               $display("FAIL dmiss_counters step%0d: got flush=%0d stall=%0d want %0d %0d", i,
                        flush_cnt0, stall_cnt0, (i == 6) ? 1 : 2, (i == 6) ? 5 : 6);
            end
         end
      end
   endtask

   task automatic test_imiss();
      in_t s; exp_t e; logic [13:0] got;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         s = idle_in();
         if (i < 3) begin
            s.ins_hit = 0;
            exp_q.push_back(mk(0, ctl(E_IMISS, F_IFID, 2'b00, 2'b00, (i == 0) ? S_RUN : S_IMISS),
                               "imiss_bubble"));
         end else begin
            exp_q.push_back(mk(0, ctl(E_ALL, F_NONE, 2'b00, 2'b00, (i == 3) ? S_IMISS : S_RUN),
                               "imiss_resume"));
         end
         drive(s);
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.w);
            total++;
            if (got !== e.v) begin
               bad++;
               $display("FAIL %s dut%0d step%0d: got %b want %b", e.name, e.w, i, got, e.v);
            end
         end
      end
      total++;
      if (stall_cnt0 !== 32'd3) begin
         bad++;
         $display("FAIL imiss_stall_cnt: got %0d want 3", stall_cnt0);
      end
   endtask

   task automatic test_timeout();
      in_t s; exp_t e; logic [13:0] got;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         s = idle_in();
         if (i < 3 || (i >= 4 && i < 7)) begin
            s.ins_hit = 0;
            exp_q.push_back(mk(2, ctl(E_IMISS, F_IFID, 2'b00, 2'b00,
                                      (i == 0 || i == 4) ? S_RUN : S_IMISS), "to_imiss"));
         end else if (i == 3 || i == 7) begin
            exp_q.push_back(mk(2, ctl(E_ALL, F_NONE, 2'b00, 2'b00, S_IMISS), "to_imiss_clear"));
         end else if (i < 12) begin
            s.data_hit = 0;
            exp_q.push_back(mk(2, ctl(E_NONE, F_NONE, 2'b00, 2'b00, (i == 8) ? S_RUN : S_DMISS),
                               "to_dmiss"));
         end else begin
            s.pc_src = 1; s.exmem_reg_write = 1; s.exmem_dest = 5; s.ex_rs = 5;
            exp_q.push_back(mk(2, ctl(E_NONE, F_NONE, 2'b00, 2'b00, S_ERR), "to_err"));
            exp_q.push_back(mk(0, ctl(E_ALL, F_BR, 2'b10, 2'b00, S_DMISS), "long_timeout_ok"));
         end
         drive(s);
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.w);
            total++;
            if (got !== e.v) begin
               bad++;
               $display("FAIL %s dut%0d step%0d: got %b want %b", e.name, e.w, i, got, e.v);
            end
         end
      end
      total++;
      if (timeout_err[2] !== 1'b1 || timeout_err[0] !== 1'b0) begin
         bad++;
         $display("FAIL timeout_flag: got %b %b want 1 0", timeout_err[2], timeout_err[0]);
      end
      for (int i = 0; i < 300; i++) drive(idle_in());
      exp_q.push_back(mk(2, ctl(E_NONE, F_NONE, 2'b00, 2'b00, S_ERR), "err_sticky"));
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got = obs(e.w);
         total++;
         if (got !== e.v) begin
            bad++;
            $display("FAIL %s dut%0d: got %b want %b", e.name, e.w, got, e.v);
         end
      end
      total++;
      if (stall_cnt2 !== 8'hFF || flush_cnt2 !== 8'h00 || timeout_err[2] !== 1'b1) begin
         bad++;
         $display("FAIL err_saturate: got stall=%0d flush=%0d terr=%b want 255 0 1",
                  stall_cnt2, flush_cnt2, timeout_err[2]);
      end
      do_reset();
      @(negedge clk);
      total++;
      if (st[2] !== S_RUN || timeout_err[2] !== 1'b0 || stall_cnt2 !== 8'h00) begin
         bad++;
         $display("FAIL err_cleared_by_rst: got st=%0d terr=%b stall=%0d want 0 0 0",
                  st[2], timeout_err[2], stall_cnt2);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_load_use();
      test_forwarding();
      test_no_fwd();
      test_dmiss_branch();
      test_imiss();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
